// File: rtl/tetris_pkg.sv
// Shared types for the Tetris input front-end: command encoding, repeat FSM
// states and the bit positions of the four game buttons.
package tetris_pkg;

  typedef enum logic [3:0] {
    OP_NONE   = 4'b0000,
    OP_RIGHT  = 4'b0001,
    OP_ROTATE = 4'b0010,
    OP_DOWN   = 4'b0100,
    OP_LEFT   = 4'b1000
  } op_e;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_ROTATE = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;

endpackage

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// Two-flop synchroniser plus debounce for one active-low button. The stable
// level only flips after the synced level has disagreed with it for
// DEBOUNCE_CYC consecutive cycles; press/release pulse on the flip edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk_1000,
  input  logic rst_n,
  input  logic raw_n,
  output logic stable_o,
  output logic press_o,
  output logic rel_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          stable_q, stable_d, press_q, press_d, rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count disagreement cycles; any agreement clears the counter.
  always_comb begin
    sync1_d  = raw_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
        rel_d    = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Released (1) is the idle level for every stage.
  always_ff @(posedge clk_1000 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;
  assign rel_o    = rel_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Button front-end for the game core: debounced presses, auto-repeat on
// LEFT/RIGHT/DOWN, fixed-priority arbitration into a 2-entry command FIFO,
// and a one-cycle restart pulse that flushes everything queued.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYC      = 20,
  parameter int REPEAT_DELAY_CYC  = 400,
  parameter int REPEAT_PERIOD_CYC = 150
) (
  input  logic       clk_1000,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  input  logic       btn_restart_n,
  input  logic       op_ack,
  output logic [3:0] op,
  output logic       op_valid,
  output logic       restart,
  output logic       overflow
);

  localparam int TMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC
                                                              : REPEAT_PERIOD_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  logic [3:0] stable, press, rel, rpt_emit, ev;
  logic       rs_stable, rs_press, rs_rel, restart_ev;
  logic       unused_ok;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_1000 (clk_1000),
      .rst_n    (rst_n),
      .raw_n    (btn_n[g]),
      .stable_o (stable[g]),
      .press_o  (press[g]),
      .rel_o    (rel[g])
    );
  end

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_restart (
    .clk_1000 (clk_1000),
    .rst_n    (rst_n),
    .raw_n    (btn_restart_n),
    .stable_o (rs_stable),
    .press_o  (rs_press),
    .rel_o    (rs_rel)
  );

  assign restart_ev = rs_press;
  // Release is tracked through the stable level, so the pulses go unused here.
  assign unused_ok  = ^{rel, rs_stable, rs_rel, stable[BTN_ROTATE]};

  for (genvar g = 0; g < 4; g++) begin : g_rpt
    if (g == BTN_ROTATE) begin : g_none
      assign rpt_emit[g] = 1'b0;
    end else begin : g_fsm
      rpt_state_e    st_q, st_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic          emit;

      // Repeat timing; a released button or restart forces IDLE and
      // suppresses an emit landing in the same cycle.
      always_comb begin
        st_d  = st_q;
        tmr_d = (tmr_q == TW'(TMAX)) ? tmr_q : tmr_q + 1'b1;
        emit  = 1'b0;
        unique case (st_q)
          RPT_IDLE: begin
            tmr_d = '0;
            if (press[g]) st_d = RPT_DELAY;
          end
          RPT_DELAY: if (tmr_q == TW'(REPEAT_DELAY_CYC - 1)) begin
            st_d  = RPT_REPEAT;
            tmr_d = '0;
            emit  = 1'b1;
          end
          RPT_REPEAT: if (tmr_q == TW'(REPEAT_PERIOD_CYC - 1)) begin
            tmr_d = '0;
            emit  = 1'b1;
          end
          default: st_d = RPT_IDLE;
        endcase
        if (stable[g] || restart_ev) begin
          st_d  = RPT_IDLE;
          tmr_d = '0;
          emit  = 1'b0;
        end
      end

      // Repeat FSM state register.
      always_ff @(posedge clk_1000 or negedge rst_n) begin
        if (!rst_n) begin
          st_q  <= RPT_IDLE;
          tmr_q <= '0;
        end else begin
          st_q  <= st_d;
          tmr_q <= tmr_d;
        end
      end

      assign rpt_emit[g] = emit;
    end
  end

  assign ev = press | rpt_emit;

  op_e        win, head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       multi, push, pop, full;
  logic       ovf_q, ovf_d, rst_q, rst_d;

  // Fixed-priority pick of at most one event per cycle.
  always_comb begin
    win = OP_NONE;
    if      (ev[BTN_ROTATE]) win = OP_ROTATE;
    else if (ev[BTN_DOWN])   win = OP_DOWN;
    else if (ev[BTN_LEFT])   win = OP_LEFT;
    else if (ev[BTN_RIGHT])  win = OP_RIGHT;
    multi = |(ev & (ev - 4'd1));
  end

  // FIFO update; head/tail are kept at OP_NONE when not occupied so op can
  // come straight from the head register.
  always_comb begin
    pop    = op_ack && (cnt_q != 2'd0);
    push   = (win != OP_NONE);
    full   = (cnt_q == 2'd2);
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    rst_d  = restart_ev;
    if (restart_ev) begin
      head_d = OP_NONE;
      tail_d = OP_NONE;
      cnt_d  = 2'd0;
    end else begin
      ovf_d = multi | (push & full & ~pop);
      if (pop) begin
        head_d = tail_q;
        tail_d = OP_NONE;
        cnt_d  = cnt_q - 2'd1;
      end
      if (push && (!full || pop)) begin
        if (cnt_d == 2'd0) head_d = win;
        else               tail_d = win;
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  // Queue and registered output pulses.
  always_ff @(posedge clk_1000 or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= OP_NONE;
      tail_q <= OP_NONE;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
      rst_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rst_q  <= rst_d;
    end
  end

  assign op       = head_q;
  assign op_valid = (cnt_q != 2'd0);
  assign overflow = ovf_q;
  assign restart  = rst_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with small debounce/repeat constants.
module tb_tetris_input_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk_1000, rst_n, btn_restart_n, op_ack;
  logic [3:0] btn_n, op;
  logic       op_valid, restart, overflow;

  int checks = 0, failures = 0;
  int ovf_seen = 0, rst_seen = 0, val_seen = 0;
  logic [3:0] exp_q[$];
  int         edge_q[$];

  tetris_input_ctrl #(
    .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_PERIOD_CYC(RP)
  ) dut (
    .clk_1000      (clk_1000),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .btn_restart_n (btn_restart_n),
    .op_ack        (op_ack),
    .op            (op),
    .op_valid      (op_valid),
    .restart       (restart),
    .overflow      (overflow)
  );

  initial clk_1000 = 1'b0;
  always #5 clk_1000 = ~clk_1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1000);
      #1;
      if (overflow) ovf_seen++;
      if (restart)  rst_seen++;
      if (op_valid) val_seen++;
    end
  endtask

  task automatic press(input logic [3:0] mask);
    btn_n = btn_n & ~mask;
    step(6);
    btn_n = btn_n | mask;
    step(14);
  endtask

  // Compare the head against the scoreboard, then acknowledge it.
  task automatic ack_cmp(input string tag);
    logic [3:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    chk({tag, "_valid"}, op_valid, 1);
    chk({tag, "_op"}, op, e);
    op_ack = 1'b1;
    step(1);
    op_ack = 1'b0;
  endtask

  initial begin
    int e, n_exp, n_iss;
    rst_n = 1'b1; btn_n = 4'hF; btn_restart_n = 1'b1; op_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_op", op, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_restart", restart, 0);
    chk("rst_overflow", overflow, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // 1: RIGHT press latency, single issue with ack held high
    op_ack = 1'b1;
    exp_q.push_back(4'b0001);
    btn_n[0] = 1'b0;
    step(D + 2);
    chk("t1_early", op_valid, 0);
    step(1);
    chk("t1_valid", op_valid, 1);
    chk("t1_op", op, exp_q.pop_front());
    step(1);
    chk("t1_pulse", op_valid, 0);
    btn_n[0] = 1'b1;
    val_seen = 0;
    step(14);
    chk("t1_norepeat", val_seen, 0);
    op_ack = 1'b0;

    // 2: DOWN bouncing faster than the debounce window
    val_seen = 0; ovf_seen = 0;
    for (int k = 0; k < 20; k++) begin
      btn_n[2] = ((k % 4) < 2) ? 1'b0 : 1'b1;
      step(1);
    end
    btn_n[2] = 1'b1;
    step(10);
    chk("t2_valid", val_seen, 0);
    chk("t2_ovf", ovf_seen, 0);

    // 3: LEFT held 40 edges, ack every cycle; model the issue edges
    e = D + 3;
    edge_q.push_back(e);
    e += RD;
    while (e <= 41 + D + 1) begin
      edge_q.push_back(e);
      e += RP;
    end
    n_exp = edge_q.size();
    n_iss = 0;
    op_ack = 1'b1;
    ovf_seen = 0;
    btn_n[3] = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      step(1);
      if (op_valid) begin
        n_iss++;
        if (edge_q.size() != 0) begin
          chk("t3_edge", t, edge_q.pop_front());
          chk("t3_op", op, 4'b1000);
        end
      end
      if (t == 40) btn_n[3] = 1'b1;
    end
    chk("t3_count", n_iss, n_exp);
    chk("t3_ovf", ovf_seen, 0);
    op_ack = 1'b0;

    // 4: ROTATE and RIGHT on the same edge
    ovf_seen = 0;
    exp_q.push_back(4'b0010);
    press(4'b0011);
    chk("t4_ovf", ovf_seen, 1);
    ack_cmp("t4");
    chk("t4_empty", op_valid, 0);

    // 5: three presses into a 2-entry queue
    ovf_seen = 0;
    exp_q.push_back(4'b0001);
    press(4'b0001);
    exp_q.push_back(4'b0100);
    press(4'b0100);
    chk("t5_no_ovf", ovf_seen, 0);
    press(4'b1000);
    chk("t5_ovf", ovf_seen, 1);
    ack_cmp("t5_a");
    ack_cmp("t5_b");
    chk("t5_empty", op_valid, 0);

    // 6: restart flushes a full queue, then async reset mid-debounce
    press(4'b0001);
    press(4'b0100);
    chk("t6_full", op_valid, 1);
    ovf_seen = 0; rst_seen = 0;
    btn_restart_n = 1'b0;
    step(D + 2);
    chk("t6_rs_early", restart, 0);
    step(1);
    chk("t6_rs_pulse", restart, 1);
    chk("t6_flush", op_valid, 0);
    step(1);
    chk("t6_rs_one", restart, 0);
    chk("t6_flush_hold", op_valid, 0);
    step(20);
    chk("t6_rs_count", rst_seen, 1);
    chk("t6_rs_ovf", ovf_seen, 0);
    btn_restart_n = 1'b1;
    step(10);

    press(4'b0001);
    chk("t6_pre_rst", op_valid, 1);
    btn_n[2] = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", op_valid, 0);
    chk("t6_rst_op", op, 0);
    chk("t6_rst_restart", restart, 0);
    chk("t6_rst_ovf", overflow, 0);
    step(1);
    rst_n = 1'b1;
    btn_n = 4'hF;
    val_seen = 0;
    step(15);
    chk("t6_post_rst", val_seen, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
